// File: rtl/lotr_pkg.sv
// Shared ring-fabric types: opcodes carried on the C2F request/response channels.
package lotr_pkg;

    typedef enum logic [1:0] {
        RD     = 2'd0,
        WR     = 2'd1,
        RD_RSP = 2'd2,
        WR_RSP = 2'd3
    } t_opcode;

endpackage

// File: rtl/uart_cmd_ctrl.sv
// Terminal command sequencer: parses 'W'/'R' host frames from the UART, issues one C2F
// request per frame, waits for the fabric response and returns ACK / read data / ERR bytes.
module uart_cmd_ctrl
    import lotr_pkg::*;
#(
    parameter int         BYTE_TIMEOUT = 65536,
    parameter int         RSP_TIMEOUT  = 1024,
    parameter logic [7:0] ACK_BYTE     = 8'h4B,
    parameter logic [7:0] ERR_BYTE     = 8'h45
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_byte_valid,
    input  logic [7:0]  rx_byte_data,
    output logic        tx_byte_valid,
    output logic [7:0]  tx_byte_data,
    input  logic        tx_byte_ready,
    output logic        C2F_ReqValidQ500H,
    output t_opcode     C2F_ReqOpcodeQ500H,
    output logic [31:0] C2F_ReqAddressQ500H,
    output logic [31:0] C2F_ReqDataQ500H,
    output logic [1:0]  C2F_ReqThreadIDQ500H,
    input  logic        C2F_RspValidQ502H,
    input  t_opcode     C2F_RspOpcodeQ502H,
    input  logic [31:0] C2F_RspDataQ502H,
    input  logic        C2F_RspStall,
    output logic        busy,
    output logic        err_pulse
);

    localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int RT_W = $clog2(RSP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, ISSUE, WAIT_RSP, SEND_RD, SEND_ACK, SEND_ERR
    } t_state;

    t_state            r_state, w_stateNext;
    logic              r_wr, w_wrNext;
    logic [31:0]       r_addr, w_addrNext;
    logic [31:0]       r_data, w_dataNext;
    logic [31:0]       r_rdata, w_rdataNext;
    logic [1:0]        r_cnt, w_cntNext;
    logic [BT_W-1:0]   r_byteTmr, w_byteTmrNext;
    logic [RT_W-1:0]   r_rspTmr, w_rspTmrNext;
    logic              r_txValid, w_txValidNext;
    logic [7:0]        r_txData, w_txDataNext;
    logic              r_err, w_err;
    logic              w_txDone;

    assign w_txDone = r_txValid && tx_byte_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_rdata   <= '0;
            r_cnt     <= '0;
            r_byteTmr <= '0;
            r_rspTmr  <= '0;
            r_txValid <= 1'b0;
            r_txData  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_wr      <= w_wrNext;
            r_addr    <= w_addrNext;
            r_data    <= w_dataNext;
            r_rdata   <= w_rdataNext;
            r_cnt     <= w_cntNext;
            r_byteTmr <= w_byteTmrNext;
            r_rspTmr  <= w_rspTmrNext;
            r_txValid <= w_txValidNext;
            r_txData  <= w_txDataNext;
            r_err     <= w_err;
        end
    end

    always_comb begin
        w_stateNext         = r_state;
        w_wrNext            = r_wr;
        w_addrNext          = r_addr;
        w_dataNext          = r_data;
        w_rdataNext         = r_rdata;
        w_cntNext           = r_cnt;
        w_byteTmrNext       = r_byteTmr;
        w_rspTmrNext        = r_rspTmr;
        w_txValidNext       = r_txValid;
        w_txDataNext        = r_txData;
        w_err               = 1'b0;
        C2F_ReqValidQ500H   = 1'b0;
        C2F_ReqOpcodeQ500H  = RD;
        C2F_ReqAddressQ500H = '0;
        C2F_ReqDataQ500H    = '0;

        case (r_state)
            IDLE: begin
                w_byteTmrNext = '0;
                w_cntNext     = '0;
                if (rx_byte_valid) begin
                    if (rx_byte_data == 8'h57) begin
                        w_stateNext = GET_ADDR;
                        w_wrNext    = 1'b1;
                    end else if (rx_byte_data == 8'h52) begin
                        w_stateNext = GET_ADDR;
                        w_wrNext    = 1'b0;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            GET_ADDR, GET_DATA: begin
                if (rx_byte_valid) begin
                    w_byteTmrNext = '0;
                    w_cntNext     = r_cnt + 2'd1;
                    if (r_state == GET_ADDR) begin
                        w_addrNext = {r_addr[23:0], rx_byte_data};
                    end else begin
                        w_dataNext = {r_data[23:0], rx_byte_data};
                    end
                    if (r_cnt == 2'd3) begin
                        w_stateNext = (r_state == GET_ADDR && r_wr) ? GET_DATA : ISSUE;
                    end
                end else if (r_byteTmr == BT_W'(BYTE_TIMEOUT - 1)) begin
                    w_stateNext = IDLE;
                    w_err       = 1'b1;
                end else begin
                    w_byteTmrNext = r_byteTmr + 1'b1;
                end
            end
            ISSUE: begin
                if (!C2F_RspStall) begin
                    C2F_ReqValidQ500H   = 1'b1;
                    C2F_ReqOpcodeQ500H  = r_wr ? WR : RD;
                    C2F_ReqAddressQ500H = r_addr;
                    C2F_ReqDataQ500H    = r_wr ? r_data : 32'h0;
                    w_rspTmrNext        = '0;
                    w_stateNext         = WAIT_RSP;
                end
            end
            // WAIT_RSP lasts at most RSP_TIMEOUT cycles; a response in the last one still wins.
            WAIT_RSP: begin
                if (C2F_RspValidQ502H && C2F_RspOpcodeQ502H == RD_RSP) begin
                    w_rdataNext   = C2F_RspDataQ502H;
                    w_cntNext     = '0;
                    w_txValidNext = 1'b1;
                    w_txDataNext  = C2F_RspDataQ502H[31:24];
                    w_stateNext   = SEND_RD;
                end else if (C2F_RspValidQ502H && C2F_RspOpcodeQ502H == WR) begin
                    w_txValidNext = 1'b1;
                    w_txDataNext  = ACK_BYTE;
                    w_stateNext   = SEND_ACK;
                end else if (r_rspTmr == RT_W'(RSP_TIMEOUT - 1)) begin
                    w_txValidNext = 1'b1;
                    w_txDataNext  = ERR_BYTE;
                    w_err         = 1'b1;
                    w_stateNext   = SEND_ERR;
                end else begin
                    w_rspTmrNext = r_rspTmr + 1'b1;
                end
            end
            SEND_RD: begin
                if (w_txDone) begin
                    if (r_cnt == 2'd3) begin
                        w_txValidNext = 1'b0;
                        w_txDataNext  = '0;
                        w_stateNext   = IDLE;
                    end else begin
                        w_cntNext    = r_cnt + 2'd1;
                        w_rdataNext  = {r_rdata[23:0], 8'h00};
                        w_txDataNext = r_rdata[23:16];
                    end
                end
            end
            SEND_ACK, SEND_ERR: begin
                if (w_txDone) begin
                    w_txValidNext = 1'b0;
                    w_txDataNext  = '0;
                    w_stateNext   = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase

        // Bytes arriving while a frame is in flight are overruns: dropped, state untouched.
        if (rx_byte_valid && (r_state inside {ISSUE, WAIT_RSP, SEND_RD, SEND_ACK, SEND_ERR})) begin
            w_err = 1'b1;
        end
    end

    assign tx_byte_valid        = r_txValid;
    assign tx_byte_data         = r_txData;
    assign C2F_ReqThreadIDQ500H = 2'd0;
    assign busy                 = (r_state != IDLE);
    assign err_pulse            = r_err;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frames plus randomized frames scored
// against a transaction-level model (expected request queue, expected TX byte queue, error count).
module tb_uart_cmd_ctrl;
    import lotr_pkg::*;

    localparam int         BT  = 300;
    localparam int         RT  = 100;
    localparam logic [7:0] ACK = 8'h4B;
    localparam logic [7:0] ERR = 8'h45;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
    } t_req;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_byte_valid;
    logic [7:0]  rx_byte_data;
    logic        tx_byte_valid;
    logic [7:0]  tx_byte_data;
    logic        tx_byte_ready;
    logic        reqValid;
    t_opcode     reqOpcode;
    logic [31:0] reqAddr;
    logic [31:0] reqData;
    logic [1:0]  reqThread;
    logic        rspValid;
    t_opcode     rspOpcode;
    logic [31:0] rspData;
    logic        rspStall;
    logic        busy;
    logic        err_pulse;

    uart_cmd_ctrl #(.BYTE_TIMEOUT(BT), .RSP_TIMEOUT(RT), .ACK_BYTE(ACK), .ERR_BYTE(ERR)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rx_byte_valid        (rx_byte_valid),
        .rx_byte_data         (rx_byte_data),
        .tx_byte_valid        (tx_byte_valid),
        .tx_byte_data         (tx_byte_data),
        .tx_byte_ready        (tx_byte_ready),
        .C2F_ReqValidQ500H    (reqValid),
        .C2F_ReqOpcodeQ500H   (reqOpcode),
        .C2F_ReqAddressQ500H  (reqAddr),
        .C2F_ReqDataQ500H     (reqData),
        .C2F_ReqThreadIDQ500H (reqThread),
        .C2F_RspValidQ502H    (rspValid),
        .C2F_RspOpcodeQ502H   (rspOpcode),
        .C2F_RspDataQ502H     (rspData),
        .C2F_RspStall         (rspStall),
        .busy                 (busy),
        .err_pulse            (err_pulse)
    );

    always #5 clk = ~clk;

    int         cycle = 0;
    int         nChecks = 0;
    int         nFail = 0;
    int         errSeen = 0;
    int         expErr = 0;
    int         txHs = 0;
    int         lastErrCycle = 0;
    int         lastRxCycle = 0;
    int         fixedStall = -1;
    int         curStall = 0;
    int         waitCnt = 0;
    bit         prevHold = 0;
    bit         expectDrop = 0;
    logic [7:0] prevData = '0;
    t_req       expReq[$];
    t_req       reqLog[$];
    logic [7:0] expTx[$];
    logic [7:0] txLog[$];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Compare process: scores every request and TX transfer against the model queues.
    always @(negedge clk) begin
        if (rst) begin
            prevHold   = 0;
            expectDrop = 0;
        end else begin
            if (expectDrop) check("txValidDropsAfterLast", tx_byte_valid, 1'b0);
            expectDrop = 0;
            check("reqThreadId", reqThread, 2'd0);
            if (reqValid) begin
                t_req e;
                t_req a;
                check("reqNotDuringStall", rspStall, 1'b0);
                check("reqExpected", expReq.size() != 0, 1'b1);
                a.op = reqOpcode; a.addr = reqAddr; a.data = reqData;
                reqLog.push_back(a);
                if (expReq.size() != 0) begin
                    e = expReq.pop_front();
                    check("reqOpcode", reqOpcode, e.op);
                    check("reqAddress", reqAddr, e.addr);
                    check("reqData", reqData, e.data);
                end
            end else begin
                check("reqOpcodeIdleZero", reqOpcode, 2'd0);
                check("reqAddrIdleZero", reqAddr, 32'h0);
                check("reqDataIdleZero", reqData, 32'h0);
            end
            if (prevHold) begin
                check("txValidHeld", tx_byte_valid, 1'b1);
                check("txDataStable", tx_byte_data, prevData);
            end
            if (tx_byte_valid && tx_byte_ready) begin
                txHs++;
                txLog.push_back(tx_byte_data);
                check("txExpected", expTx.size() != 0, 1'b1);
                if (expTx.size() != 0) begin
                    check("txByte", tx_byte_data, expTx.pop_front());
                    if (expTx.size() == 0) expectDrop = 1;
                end
            end
            prevHold = tx_byte_valid && !tx_byte_ready;
            prevData = tx_byte_data;
            if (err_pulse) begin
                errSeen++;
                lastErrCycle = cycle;
            end
        end
    end

    // TX engine stand-in: stalls each offered byte for curStall cycles before accepting it.
    initial begin
        tx_byte_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !tx_byte_valid) begin
                tx_byte_ready = 1'b0;
                waitCnt = 0;
                curStall = (fixedStall >= 0) ? fixedStall : int'($urandom_range(0, 2));
            end else if (waitCnt >= curStall) begin
                tx_byte_ready = 1'b1;
                waitCnt = 0;
                curStall = (fixedStall >= 0) ? fixedStall : int'($urandom_range(0, 2));
            end else begin
                tx_byte_ready = 1'b0;
                waitCnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        rx_byte_data  = b;
        rx_byte_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_byte_valid = 1'b0;
        rx_byte_data  = '0;
        lastRxCycle   = cycle;
    endtask

    task automatic checkOutput();
        check("txQueueDrained", expTx.size(), 0);
        check("reqQueueDrained", expReq.size(), 0);
        check("errPulseCount", errSeen, expErr);
    endtask

    // One complete host frame; the model decides the request and the bytes returned to the host.
    task automatic applyStimulus(input bit isWr, input logic [31:0] addr, input logic [31:0] data,
                                 input bit rspNone, input logic [31:0] rdData, input int rspDelay,
                                 input int stallCyc, input int gap, input bit overrun,
                                 input int resetAfter);
        t_req r;
        int   base;
        bit   ok;
        bit   accept;
        r.op   = isWr ? WR : RD;
        r.addr = addr;
        r.data = isWr ? data : 32'h0;
        expReq.push_back(r);
        base = txHs;
        if (stallCyc > 0) rspStall = 1'b1;
        sendByte(isWr ? 8'h57 : 8'h52);
        for (int i = 0; i < 4; i++) begin
            tick(gap);
            sendByte(addr[31-8*i -: 8]);
        end
        if (isWr) begin
            for (int i = 0; i < 4; i++) begin
                tick(gap);
                sendByte(data[31-8*i -: 8]);
            end
        end
        if (stallCyc == 0) begin
            @(negedge clk);
            check("reqOneCycleAfterLastByte", reqValid, 1'b1);
        end else begin
            for (int s = 0; s < stallCyc; s++) begin
                @(negedge clk);
                check("reqHeldByStall", reqValid, 1'b0);
                @(posedge clk);
                #1;
            end
            rspStall = 1'b0;
            @(negedge clk);
            check("reqFirstCycleAfterStall", reqValid, 1'b1);
        end
        @(posedge clk);
        #1;
        accept = !rspNone && (rspDelay <= RT - 1);
        if (accept) begin
            if (isWr) expTx.push_back(ACK);
            else for (int i = 0; i < 4; i++) expTx.push_back(rdData[31-8*i -: 8]);
        end else begin
            expTx.push_back(ERR);
            expErr++;
        end
        if (overrun) begin
            sendByte(8'h57);
            expErr++;
        end
        if (!rspNone) begin
            tick(rspDelay - (overrun ? 1 : 0));
            rspValid  = 1'b1;
            rspOpcode = isWr ? WR : RD_RSP;
            rspData   = rdData;
            @(posedge clk);
            #1;
            rspValid  = 1'b0;
            rspOpcode = RD;
            rspData   = '0;
        end
        if (resetAfter >= 0) begin
            ok = 0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (txHs >= base + resetAfter) begin
                    ok = 1;
                    break;
                end
            end
            check("resetPointReached", ok, 1'b1);
            @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            check("rstTxValid", tx_byte_valid, 1'b0);
            check("rstTxData", tx_byte_data, 8'h00);
            check("rstReqValid", reqValid, 1'b0);
            check("rstBusy", busy, 1'b0);
            check("rstErrPulse", err_pulse, 1'b0);
            expTx.delete();
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
        ok = 0;
        for (int k = 0; k < RT + 200; k++) begin
            @(negedge clk);
            if (!busy && !tx_byte_valid) begin
                ok = 1;
                break;
            end
        end
        check("frameCompletes", ok, 1'b1);
        @(posedge clk);
        #1;
        tick(2);
        checkOutput();
    endtask

    initial begin
        int          n0;
        int          d;
        logic [7:0]  b;
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] rd;
        int          dly;
        bit          none;
        bit          ovr;
        bit          isWr;

        rst           = 1'b1;
        rx_byte_valid = 1'b0;
        rx_byte_data  = '0;
        rspValid      = 1'b0;
        rspOpcode     = RD;
        rspData       = '0;
        rspStall      = 1'b0;
        @(negedge clk);
        check("resetTxValid", tx_byte_valid, 1'b0);
        check("resetTxData", tx_byte_data, 8'h00);
        check("resetReqValid", reqValid, 1'b0);
        check("resetReqOpcode", reqOpcode, 2'd0);
        check("resetReqAddr", reqAddr, 32'h0);
        check("resetReqData", reqData, 32'h0);
        check("resetBusy", busy, 1'b0);
        check("resetErrPulse", err_pulse, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);

        $display("[TB] write frame with ACK");
        n0 = txLog.size();
        applyStimulus(1'b1, 32'h12345678, 32'hDEADBEEF, 1'b0, 32'h0, 3, 0, 0, 1'b0, -1);
        check("w1ReqOpcode", reqLog[reqLog.size()-1].op, 2'd1);
        check("w1ReqAddr", reqLog[reqLog.size()-1].addr, 32'h12345678);
        check("w1ReqData", reqLog[reqLog.size()-1].data, 32'hDEADBEEF);
        check("w1TxCount", txLog.size() - n0, 1);
        check("w1TxAck", txLog[n0], 8'h4B);

        $display("[TB] read frame with slow TX");
        fixedStall = 3;
        n0 = txLog.size();
        applyStimulus(1'b0, 32'h00001000, 32'h0, 1'b0, 32'hCAFEF00D, 5, 0, 1, 1'b0, -1);
        fixedStall = -1;
        check("r2ReqOpcode", reqLog[reqLog.size()-1].op, 2'd0);
        check("r2ReqAddr", reqLog[reqLog.size()-1].addr, 32'h00001000);
        check("r2ReqData", reqLog[reqLog.size()-1].data, 32'h0);
        check("r2TxCount", txLog.size() - n0, 4);
        check("r2TxByte0", txLog[n0], 8'hCA);
        check("r2TxByte1", txLog[n0+1], 8'hFE);
        check("r2TxByte2", txLog[n0+2], 8'hF0);
        check("r2TxByte3", txLog[n0+3], 8'h0D);

        $display("[TB] read frame under fabric stall");
        applyStimulus(1'b0, 32'hA5A50004, 32'h0, 1'b0, 32'h01020304, 2, 10, 0, 1'b0, -1);

        $display("[TB] response timeout and boundaries");
        n0 = txLog.size();
        applyStimulus(1'b0, 32'h00000040, 32'h0, 1'b1, 32'h0, 0, 0, 0, 1'b0, -1);
        check("t4TxErr", txLog[n0], 8'h45);
        applyStimulus(1'b1, 32'h00000044, 32'h55AA55AA, 1'b0, 32'h0, 0, 0, 0, 1'b0, -1);
        applyStimulus(1'b0, 32'h00000048, 32'h0, 1'b0, 32'h11223344, RT - 1, 0, 0, 1'b0, -1);
        applyStimulus(1'b1, 32'h0000004C, 32'h00000001, 1'b0, 32'h0, RT, 0, 0, 1'b0, -1);

        $display("[TB] inter-byte timeout and bad opcode");
        sendByte(8'h57);
        sendByte(8'h12);
        expErr++;
        tick(BT + 5);
        d = lastErrCycle - lastRxCycle;
        check("byteTimeoutWindow", (d >= BT - 1) && (d <= BT + 1), 1'b1);
        check("byteTimeoutIdle", busy, 1'b0);
        sendByte(8'h41);
        expErr++;
        tick(3);
        check("badOpcodeIdle", busy, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 32'h0BADF00D, 32'h0, 1'b0, 32'h89ABCDEF, 1, 0, BT - 20, 1'b0, -1);

        $display("[TB] reset in the middle of read data");
        fixedStall = 0;
        applyStimulus(1'b0, 32'h00000100, 32'h0, 1'b0, 32'hFEEDFACE, 2, 0, 0, 1'b0, 2);
        fixedStall = -1;
        applyStimulus(1'b0, 32'h00000104, 32'h0, 1'b0, 32'h13579BDF, 4, 0, 0, 1'b0, -1);

        $display("[TB] randomized frames");
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h57 || b == 8'h52) b = 8'h41;
                sendByte(b);
                expErr++;
                tick(1);
            end
            isWr = 1'($urandom_range(0, 1));
            a    = $urandom;
            w    = $urandom;
            rd   = $urandom;
            none = ($urandom_range(0, 9) == 0);
            dly  = int'($urandom_range(0, 12));
            ovr  = ($urandom_range(0, 4) == 0) && (none || dly >= 1);
            applyStimulus(isWr, a, w, none, rd, dly,
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                          int'($urandom_range(0, 3)), ovr, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #800000;
        nFail++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, limit 800000", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
